icap_stream_writer: RTL and testbench

//  Drives the ICAP primitive for partial reconfiguration: streams bitstream words from an upstream DMA/FIFO
//  (valid/ready) into ICAP, generating active-low CSIB, RDWRB and 32-bit data.

---
 rtl/prcontrol_pkg.sv | 20 ++
 rtl/icap_bitswap.sv | 21 ++
 rtl/icap_stream_writer.sv | 161 ++++++++++++++++
 tb/tb_icap_stream_writer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prcontrol_pkg.sv
// Purpose : shared constants and the stream-writer state encoding for partial-reconfiguration control.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: ICAP_DATA_W, STAT_CNT_W, STALL_CNT_W, wr_state_t.
package prcontrol_pkg;

   localparam int ICAP_DATA_W = 32;
   localparam int STAT_CNT_W  = 20;
   // Wide enough for any stall timeout up to 2^16-1.
   localparam int STALL_CNT_W = 16;

   typedef enum logic [2:0] {
      WR_IDLE   = 3'd0,
      WR_ARM    = 3'd1,
      WR_STREAM = 3'd2,
      WR_FINISH = 3'd3,
      WR_ERROR  = 3'd4
   } wr_state_t;

endpackage

// File: rtl/icap_bitswap.sv
// Purpose : reverses the bit order inside every byte (bit 0<->7), as ICAP expects for raw .bin data.
// Latency : combinational.
// Backpressure: none, pure function of the input.
// Ports   : din (DATA_W) word in, dout (DATA_W) byte-wise bit-reversed word out.
module icap_bitswap #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   always_comb begin
      dout = '0;
      for (int b = 0; b < DATA_W / 8; b++) begin
         for (int i = 0; i < 8; i++) begin
            dout[8*b + 7 - i] = din[8*b + i];
         end
      end
   end

endmodule

// File: rtl/icap_stream_writer.sv
// Purpose : streams bitstream words from a valid/ready source into the ICAP primitive (CSIB/RDWRB/data).
// Latency : accepted word appears on o_icap_data with CSIB low one cycle after the handshake.
// Backpressure: s_ready is high only in STREAM; upstream stalls otherwise, stall timeout ends in ERROR.
// Ports   : i_clk, i_rst (sync, active high); i_start/i_abort/i_word_count control;
//           s_data/s_valid/s_ready stream in; o_icap_csib/o_icap_rdwrb/o_icap_data to ICAP;
//           o_config_start/o_done pulses, o_busy, o_error (sticky).
// Config  : define ICAP_BITSWAP_EN to bit-reverse each byte of s_data before it reaches ICAP.
module icap_stream_writer
   import prcontrol_pkg::*;
#(
   parameter int DATA_W        = ICAP_DATA_W,
   parameter int CNT_W         = STAT_CNT_W,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [CNT_W-1:0]  i_word_count,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              o_icap_csib,
   output logic              o_icap_rdwrb,
   output logic [DATA_W-1:0] o_icap_data,
   output logic              o_config_start,
   output logic              o_done,
   output logic              o_busy,
   output logic              o_error
);

   wr_state_t              state, next_state;
   logic [CNT_W-1:0]       remaining, remaining_d;
   logic [STALL_CNT_W-1:0] stall_cnt, stall_d;
   logic [DATA_W-1:0]      wr_word, data_d;
   logic                   csib_d, rdwrb_d, cfg_d, done_d, error_d, busy_d;
   logic                   beat, start_ok, start_nz, stall_hit;

`ifdef ICAP_BITSWAP_EN
   icap_bitswap #(.DATA_W(DATA_W)) u_bitswap (.din(s_data), .dout(wr_word));
`else
   assign wr_word = s_data;
`endif

   assign s_ready   = (state == WR_STREAM);
   // Abort wins over a coincident beat, including the last one.
   assign beat      = s_ready && s_valid && !i_abort;
   assign start_nz  = (i_word_count != '0);
   // In ERROR an abort takes precedence over a simultaneous start.
   assign start_ok  = i_start && ((state == WR_IDLE) || ((state == WR_ERROR) && !i_abort));
   assign stall_hit = ((stall_cnt + STALL_CNT_W'(1)) == STALL_CNT_W'(STALL_TIMEOUT));

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= WR_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         WR_IDLE:   if (start_ok && start_nz) next_state = WR_ARM;
         WR_ARM:    next_state = i_abort ? WR_IDLE : WR_STREAM;
         WR_STREAM: begin
            if (i_abort)                                next_state = WR_IDLE;
            else if (beat && (remaining == CNT_W'(1)))  next_state = WR_FINISH;
            else if (!beat && stall_hit)                next_state = WR_ERROR;
         end
         // First FINISH cycle still carries the last write (CSIB low); leave after the hold cycle.
         WR_FINISH: if (i_abort || o_icap_csib) next_state = WR_IDLE;
         WR_ERROR: begin
            if (i_abort)       next_state = WR_IDLE;
            else if (start_ok) next_state = start_nz ? WR_ARM : WR_IDLE;
         end
         default:   next_state = WR_IDLE;
      endcase
   end

   always_comb begin
      csib_d      = 1'b1;
      rdwrb_d     = o_icap_rdwrb;
      data_d      = o_icap_data;
      cfg_d       = 1'b0;
      done_d      = 1'b0;
      error_d     = o_error;
      remaining_d = remaining;
      stall_d     = stall_cnt;
      unique case (state)
         WR_IDLE, WR_ERROR: begin
            if ((state == WR_ERROR) && i_abort) begin
               error_d = 1'b0;
               rdwrb_d = 1'b1;
            end
            if (start_ok) begin
               error_d = 1'b0;
               if (start_nz) begin
                  remaining_d = i_word_count;
                  stall_d     = '0;
                  cfg_d       = 1'b1;
                  rdwrb_d     = 1'b0;
               end else begin
                  done_d      = 1'b1;
               end
            end
         end
         WR_ARM: if (i_abort) rdwrb_d = 1'b1;
         WR_STREAM: begin
            if (i_abort) begin
               rdwrb_d = 1'b1;
            end else if (beat) begin
               data_d      = wr_word;
               csib_d      = 1'b0;
               remaining_d = remaining - CNT_W'(1);
               stall_d     = '0;
            end else begin
               stall_d = stall_cnt + STALL_CNT_W'(1);
               if (stall_hit) begin
                  rdwrb_d = 1'b1;
                  error_d = 1'b1;
               end
            end
         end
         WR_FINISH: begin
            // RDWRB stays low for one cycle after CSIB rises, then the transfer closes.
            if (i_abort) begin
               rdwrb_d = 1'b1;
            end else if (o_icap_csib) begin
               rdwrb_d = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: rdwrb_d = 1'b1;
      endcase
   end

   assign busy_d = (next_state == WR_ARM) || (next_state == WR_STREAM) || (next_state == WR_FINISH);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_icap_csib    <= 1'b1;
         o_icap_rdwrb   <= 1'b1;
         o_icap_data    <= '0;
         o_config_start <= 1'b0;
         o_done         <= 1'b0;
         o_busy         <= 1'b0;
         o_error        <= 1'b0;
         remaining      <= '0;
         stall_cnt      <= '0;
      end else begin
         o_icap_csib    <= csib_d;
         o_icap_rdwrb   <= rdwrb_d;
         o_icap_data    <= data_d;
         o_config_start <= cfg_d;
         o_done         <= done_d;
         o_busy         <= busy_d;
         o_error        <= error_d;
         remaining      <= remaining_d;
         stall_cnt      <= stall_d;
      end
   end

endmodule

// File: tb/tb_icap_stream_writer.sv
// Purpose : self-checking bench for icap_stream_writer with a queue scoreboard and independent monitor.
// Latency : n/a.
// Backpressure: n/a.
module tb_icap_stream_writer;

   localparam int TMO = 8;
   localparam logic [31:0] SWAP_WORD = 32'h01020380;
`ifdef ICAP_BITSWAP_EN
   localparam logic [31:0] SWAP_EXP  = 32'h8040C001;
`else
   localparam logic [31:0] SWAP_EXP  = 32'h01020380;
`endif

   logic        i_clk, i_rst, i_start, i_abort, s_valid;
   logic [19:0] i_word_count;
   logic [31:0] s_data;
   logic        s_ready, o_icap_csib, o_icap_rdwrb, o_config_start, o_done, o_busy, o_error;
   logic [31:0] o_icap_data;

   icap_stream_writer #(.DATA_W(32), .CNT_W(20), .STALL_TIMEOUT(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
      .i_word_count(i_word_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .o_icap_csib(o_icap_csib), .o_icap_rdwrb(o_icap_rdwrb), .o_icap_data(o_icap_data),
      .o_config_start(o_config_start), .o_done(o_done), .o_busy(o_busy), .o_error(o_error)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [31:0] dat;
      int          cyc;
   } wr_t;
   wr_t exp_wr[$];
   int  exp_cfg[$];
   int  exp_done[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got %h with nothing expected (cycle %0d)", name, act, cyc);
   endtask

   // ICAP sees every byte bit-reversed when the swap option is built in.
   function automatic logic [31:0] ref_data(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
      logic [31:0] r;
      for (int k = 0; k < 32; k++) r[(k / 8) * 8 + 7 - (k % 8)] = w[k];
      return r;
`else
      return w;
`endif
   endfunction

   // Monitor: every ICAP write and every pulse must match the head of its queue.
   always @(negedge i_clk) begin
      if (mon_en) begin
         if (o_icap_csib === 1'b0) begin
            chk("wr_rdwrb_low", o_icap_rdwrb, 0);
            if (exp_wr.size() == 0) unexpected("write", o_icap_data);
            else begin
               wr_t e;
               e = exp_wr.pop_front();
               chk("wr_data", o_icap_data, e.dat);
               chk("wr_cycle", cyc, e.cyc);
            end
         end
         if (o_config_start === 1'b1) begin
            if (exp_cfg.size() == 0) unexpected("config_start", cyc);
            else chk("cfg_cycle", cyc, exp_cfg.pop_front());
         end
         if (o_done === 1'b1) begin
            if (exp_done.size() == 0) unexpected("done", cyc);
            else chk("done_cycle", cyc, exp_done.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_csib"},  o_icap_csib, 1);
      chk({tag, "_rdwrb"}, o_icap_rdwrb, 1);
      chk({tag, "_data"},  o_icap_data, 0);
      chk({tag, "_ready"}, s_ready, 0);
      chk({tag, "_cfg"},   o_config_start, 0);
      chk({tag, "_done"},  o_done, 0);
      chk({tag, "_busy"},  o_busy, 0);
      chk({tag, "_error"}, o_error, 0);
   endtask

   // One transfer. gap: fixed idle cycles between words, <0 random 0..3.
   // mode: 0 random words, 1 words 0x11,0x22.., 2 the bit-swap word.
   // supply: words offered before going silent. stop_at: accepted-word count at which
   // stop_kind (0 abort, 1 reset) is applied, <0 never. restart_at: pulse i_start while busy.
   task automatic xfer(input int cnt, input int gap, input int mode, input int supply,
                       input int stop_at, input int stop_kind, input int restart_at);
      int acc, starve, gap_left;
      bit have_w, hs;
      logic [31:0] w, last_exp;
      i_start = 1'b1;
      i_word_count = 20'(cnt);
      if (cnt != 0) exp_cfg.push_back(cyc + 1);
      else          exp_done.push_back(cyc + 1);
      @(negedge i_clk);
      i_start = 1'b0;
      if (cnt == 0) begin
         chk("zero_busy", o_busy, 0);
         chk("zero_csib", o_icap_csib, 1);
         return;
      end
      chk("arm_busy", o_busy, 1);
      chk("arm_rdwrb", o_icap_rdwrb, 0);
      chk("arm_csib", o_icap_csib, 1);
      chk("arm_ready", s_ready, 0);
      chk("arm_error", o_error, 0);
      acc = 0; starve = 0; gap_left = 0; have_w = 0; w = '0; last_exp = '0;
      for (int it = 0; it < 300; it++) begin
         if (acc == stop_at) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            if (stop_kind == 0) i_abort = 1'b1;
            else                i_rst   = 1'b1;
            @(negedge i_clk);
            i_abort = 1'b0;
            s_valid = 1'b0;
            if (stop_kind == 0) begin
               chk("abort_csib", o_icap_csib, 1);
               chk("abort_rdwrb", o_icap_rdwrb, 1);
               chk("abort_busy", o_busy, 0);
               chk("abort_ready", s_ready, 0);
            end else begin
               chk_reset_outputs("midrst");
               i_rst = 1'b0;
            end
            idle(4);
            return;
         end
         if (acc >= supply) s_valid = 1'b0;
         else if (gap_left > 0) begin
            s_valid = 1'b0;
            gap_left--;
         end else begin
            if (!have_w) begin
               w = (mode == 1) ? 32'(8'h11 * (acc + 1)) : (mode == 2) ? SWAP_WORD : $urandom;
               have_w = 1'b1;
            end
            s_valid = 1'b1;
            s_data  = w;
         end
         i_start = (restart_at >= 0) && (acc == restart_at);
         i_word_count = i_start ? 20'd1 : 20'(cnt);
         hs = s_valid && s_ready;
         if (hs) begin
            last_exp = (mode == 2) ? SWAP_EXP : ref_data(w);
            exp_wr.push_back('{dat: last_exp, cyc: cyc + 1});
            acc++;
            have_w = 1'b0;
            starve = 0;
            gap_left = (gap < 0) ? $urandom_range(0, 3) : gap;
            // Last write is on ICAP one cycle after the handshake, done two cycles after that.
            if (acc == cnt) exp_done.push_back(cyc + 3);
         end else if (s_ready) begin
            starve++;
         end
         if (starve == TMO - 1) chk("no_early_error", o_error, 0);
         @(negedge i_clk);
         i_start = 1'b0;
         if (starve == TMO) begin
            s_valid = 1'b0;
            chk("stall_error", o_error, 1);
            chk("stall_csib", o_icap_csib, 1);
            chk("stall_rdwrb", o_icap_rdwrb, 1);
            chk("stall_busy", o_busy, 0);
            idle(3);
            chk("error_sticky", o_error, 1);
            return;
         end
         if (acc == cnt) begin
            s_valid = 1'b0;
            chk("last_ready", s_ready, 0);
            @(negedge i_clk);
            chk("fin_csib", o_icap_csib, 1);
            chk("fin_rdwrb", o_icap_rdwrb, 0);
            @(negedge i_clk);
            chk("end_rdwrb", o_icap_rdwrb, 1);
            chk("end_busy", o_busy, 0);
            chk("data_hold", o_icap_data, last_exp);
            idle(2);
            return;
         end
      end
      unexpected("xfer_timeout", acc);
      s_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; s_valid = 1'b0;
      i_word_count = '0; s_data = '0;
      idle(3);
      chk_reset_outputs("reset");
      i_rst = 1'b0;
      mon_en = 1'b1;
      idle(2);

      xfer(4, 0, 1, 4, -1, 0, -1);          // back-to-back words 0x11..0x44
      xfer(3, 2, 0, 3, -1, 0, -1);          // two-cycle gaps between words
      xfer(2, 0, 0, 1, -1, 0, -1);          // starved after one word -> ERROR
      xfer(3, -1, 0, 3, -1, 0, -1);         // start out of ERROR clears it
      xfer(8, -1, 0, 8, 3, 0, -1);          // abort with five words remaining
      xfer(2, 0, 0, 2, -1, 0, -1);          // normal transfer after abort
      xfer(0, 0, 0, 0, -1, 0, -1);          // zero count: done only
      idle(2);
      xfer(5, -1, 0, 5, -1, 0, 2);          // start while busy is ignored
      xfer(1, 0, 2, 1, -1, 0, -1);          // bit-swap reference word
      xfer(6, 0, 0, 6, 2, 1, -1);           // reset mid-stream
      for (int t = 0; t < 8; t++) xfer($urandom_range(1, 7), -1, 0, 99, -1, 0, -1);

      idle(3);
      chk("pending_writes", exp_wr.size(), 0);
      chk("pending_cfg", exp_cfg.size(), 0);
      chk("pending_done", exp_done.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
